execute_stage_mc: RTL and testbench
===================================

# execute_stage_mc

Parametrised execute stage for the pipelined ARMv8 core, sitting between the ID/EX and EX/MEM boundaries. It selects forwarded operands, executes single-cycle ALU operations and an iterative multi-cycle multiply, computes the branch target, and owns the EX/MEM output register. While a multiply is in flight it stalls the upstream pipeline and presents bubbles downstream.

## Interface
Parameters:
- XLEN, 64, datapath width; power of two, ≥ 8.
- MUL_BITS, 4, multiplier bits retired per iteration; divides XLEN. Iterations N = XLEN/MUL_BITS.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX holds a valid instruction.
- flush  in  1  discard the current and in-flight instruction.
- pc  in  XLEN  instruction PC.
- read_data_1, read_data_2  in  XLEN  register-file operands.
- imm  in  XLEN  sign-extended immediate.
- alu_src  in  1  1 = operand B is imm, 0 = forwarded read_data_2.
- alu_ctrl  in  4  decoded operation (see Operation).
- rd  in  5  destination register; reg_write in 1 write-enable.
- forward_a, forward_b  in  2  00 register, 10 EX/MEM, 01 WB, 11 treated as 00.
- ex_mem_fwd, wb_fwd  in  XLEN  forwarding sources.
- stall  out  1  upstream must hold ID/EX; equals busy register.
- out_valid  out  1  EX/MEM entry valid.
- out_result, out_store_data, out_branch_target  out  XLEN  registered results.
- out_zero  out  1  out_result == 0.
- out_rd  out  5; out_reg_write  out  1.

## Operation
- Operand A = forward_a mux(read_data_1, ex_mem_fwd, wb_fwd).
- Forwarded B = forward_b mux(read_data_2, ex_mem_fwd, wb_fwd), applied before the alu_src mux; out_store_data is always forwarded B.
- alu_ctrl: 0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR, 1001 LSL, 1010 LSR, 1000 MUL; all other codes yield 0.
- ADD/SUB wrap mod 2^XLEN. Shifts use B[log2(XLEN)-1:0] only. MUL returns the low XLEN bits of the product.
- out_branch_target = pc + (imm << 2), mod 2^XLEN.
- Two states: IDLE and MUL_BUSY.
  - IDLE, in_valid, no flush, non-MUL op: register all outputs at the edge; out_valid = 1.
  - IDLE, in_valid, no flush, MUL: latch A, B, rd, reg_write, pc-derived target and store data; clear the accumulator; go to MUL_BUSY. out_valid = 0 at that edge.
  - MUL_BUSY: each edge adds (A << (i·MUL_BITS)) · B[i·MUL_BITS +: MUL_BITS] to the accumulator, i = 0..N-1. At the N-th edge it writes the final product to out_result, sets out_valid = 1 and returns to IDLE. out_valid = 0 on all earlier edges.
  - While busy, in_valid and the operand inputs are ignored (held upstream by stall).
- flush: at the edge, out_valid ← 0, any MUL is aborted (→ IDLE) and nothing is accepted. flush overrides in_valid.
- in_valid = 0 in IDLE: out_valid ← 0; data outputs hold their previous values.

## Timing
- Reset (async assert): state IDLE, stall 0, out_valid 0, every data output 0, out_zero 0, out_rd 0, out_reg_write 0. Deassertion is synchronised externally.
- Single-cycle ops: latency 1; a result accepted at edge k is visible after edge k.
- MUL accepted at edge k: stall = 1 after k through edge k+N-1; result valid after edge k+N; stall = 0 after k+N. With defaults, N = 16.
- The next instruction may be accepted at edge k+N+1, and a back-to-back MUL restarts at that edge.
- stall is a registered output with no combinational path from inputs.
- out_zero is registered together with out_result.

## Test plan
- ADD, forward_a = 10, ex_mem_fwd = 7, alu_src = 1, imm = 5 -> next cycle out_result = 12, out_zero = 0, out_valid = 1.
- SUB 9 − 9 with forward_b = 01, wb_fwd = 9 -> out_result = 0, out_zero = 1; out_store_data = 9.
- MUL 0xFFFF_FFFF_FFFF_FFFF × 3 (defaults) -> stall high 16 cycles, out_valid low throughout; then out_result = 0xFFFF_FFFF_FFFF_FFFD with a single out_valid pulse.
- flush asserted in MUL_BUSY iteration 5 -> stall drops next edge, out_valid never pulses, a subsequent ADD completes normally; rst_n low mid-MUL -> all outputs 0 immediately.
- LSL 1 by B = 70, forward code 11 on A -> shift by 6, out_result = 64; out_branch_target = pc + 4·imm for pc = 0x1000, imm = −2 -> 0xFF8.
- XLEN = 32, MUL_BITS = 8: 0x1234 × 0x10 -> 0x12340 after 4 busy cycles; undefined alu_ctrl 1111 -> out_result = 0, out_zero = 1.

Source files
------------

// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply, branch target, EX/MEM register.
// Latency: 1 cycle for ALU ops, XLEN/MUL_BITS+1 edges for MUL (accept edge plus one edge per iteration).
// Backpressure: stall is high while a multiply iterates; flush aborts it; outputs are bubbles until done.
module execute_stage_mc #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] read_data_1,
    input  logic [XLEN-1:0] read_data_2,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [3:0]      alu_ctrl,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic [1:0]      forward_a,
    input  logic [1:0]      forward_b,
    input  logic [XLEN-1:0] ex_mem_fwd,
    input  logic [XLEN-1:0] wb_fwd,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_branch_target,
    output logic            out_zero,
    output logic [4:0]      out_rd,
    output logic            out_reg_write
);

    localparam int N   = XLEN / MUL_BITS;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int SHW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_PSB = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t          state_q;
    logic [XLEN-1:0] mul_a_q, mul_b_q, acc_q;
    logic [CW-1:0]   cnt_q;
    logic [4:0]      mul_rd_q;
    logic            mul_regw_q;
    logic [XLEN-1:0] mul_tgt_q, mul_store_q;

    logic            out_valid_q, out_zero_q, out_regw_q;
    logic [XLEN-1:0] out_result_q, out_store_q, out_tgt_q;
    logic [4:0]      out_rd_q;

    logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, target, partial, acc_d;
    logic [SHW-1:0]  shamt;

    // Operand selection: forwarding muxes (code 11 falls back to the register file), then immediate select
    always_comb begin
        op_a = read_data_1;
        case (forward_a)
            2'b10:   op_a = ex_mem_fwd;
            2'b01:   op_a = wb_fwd;
            default: op_a = read_data_1;
        endcase
        fwd_b = read_data_2;
        case (forward_b)
            2'b10:   fwd_b = ex_mem_fwd;
            2'b01:   fwd_b = wb_fwd;
            default: fwd_b = read_data_2;
        endcase
        op_b   = alu_src ? imm : fwd_b;
        shamt  = op_b[SHW-1:0];
        target = pc + (imm << 2);
    end

    // Single-cycle ALU; MUL and undefined codes produce zero here
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            OP_AND:  alu_res = op_a & op_b;
            OP_ORR:  alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_PSB:  alu_res = op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_LSL:  alu_res = op_a << shamt;
            OP_LSR:  alu_res = op_a >> shamt;
            default: alu_res = '0;
        endcase
    end

    // One multiply digit per cycle: A is pre-shifted and B consumed from its low end each iteration
    always_comb begin
        partial = mul_a_q * XLEN'(mul_b_q[MUL_BITS-1:0]);
        acc_d   = acc_q + partial;
    end

    // Control FSM and EX/MEM register; out_valid defaults to a bubble every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            mul_rd_q     <= '0;
            mul_regw_q   <= 1'b0;
            mul_tgt_q    <= '0;
            mul_store_q  <= '0;
            out_valid_q  <= 1'b0;
            out_zero_q   <= 1'b0;
            out_regw_q   <= 1'b0;
            out_result_q <= '0;
            out_store_q  <= '0;
            out_tgt_q    <= '0;
            out_rd_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (in_valid) begin
                            if (alu_ctrl == OP_MUL) begin
                                mul_a_q     <= op_a;
                                mul_b_q     <= op_b;
                                acc_q       <= '0;
                                cnt_q       <= '0;
                                mul_rd_q    <= rd;
                                mul_regw_q  <= reg_write;
                                mul_tgt_q   <= target;
                                mul_store_q <= fwd_b;
                                state_q     <= MUL_BUSY;
                            end else begin
                                out_result_q <= alu_res;
                                out_zero_q   <= (alu_res == '0);
                                out_store_q  <= fwd_b;
                                out_tgt_q    <= target;
                                out_rd_q     <= rd;
                                out_regw_q   <= reg_write;
                                out_valid_q  <= 1'b1;
                            end
                        end
                    end
                    MUL_BUSY: begin
                        acc_q   <= acc_d;
                        mul_a_q <= mul_a_q << MUL_BITS;
                        mul_b_q <= mul_b_q >> MUL_BITS;
                        cnt_q   <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            out_result_q <= acc_d;
                            out_zero_q   <= (acc_d == '0);
                            out_store_q  <= mul_store_q;
                            out_tgt_q    <= mul_tgt_q;
                            out_rd_q     <= mul_rd_q;
                            out_regw_q   <= mul_regw_q;
                            out_valid_q  <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign stall             = (state_q == MUL_BUSY);
    assign out_valid         = out_valid_q;
    assign out_result        = out_result_q;
    assign out_store_data    = out_store_q;
    assign out_branch_target = out_tgt_q;
    assign out_zero          = out_zero_q;
    assign out_rd            = out_rd_q;
    assign out_reg_write     = out_regw_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
module tb_execute_stage_mc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 64-bit default instance
    logic        in_valid, flush, alu_src, reg_write;
    logic [63:0] pc, rd1, rd2, imm, exf, wbf;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
    logic        stall, out_valid, out_zero, out_reg_write;
    logic [63:0] out_result, out_store_data, out_branch_target;
    logic [4:0]  out_rd;

    // 32-bit, 8-bit-digit instance
    logic        s_in_valid, s_flush, s_alu_src, s_reg_write;
    logic [31:0] s_pc, s_rd1, s_rd2, s_imm, s_exf, s_wbf;
    logic [3:0]  s_alu_ctrl;
    logic [4:0]  s_rd;
    logic [1:0]  s_fa, s_fb;
    logic        s_stall, s_out_valid, s_out_zero, s_out_reg_write;
    logic [31:0] s_out_result, s_out_store_data, s_out_branch_target;
    logic [4:0]  s_out_rd;

    execute_stage_mc dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush), .pc(pc),
        .read_data_1(rd1), .read_data_2(rd2), .imm(imm), .alu_src(alu_src),
        .alu_ctrl(alu_ctrl), .rd(rd), .reg_write(reg_write), .forward_a(fa),
        .forward_b(fb), .ex_mem_fwd(exf), .wb_fwd(wbf), .stall(stall),
        .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
        .out_branch_target(out_branch_target), .out_zero(out_zero), .out_rd(out_rd),
        .out_reg_write(out_reg_write)
    );

    execute_stage_mc #(.XLEN(32), .MUL_BITS(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .flush(s_flush), .pc(s_pc),
        .read_data_1(s_rd1), .read_data_2(s_rd2), .imm(s_imm), .alu_src(s_alu_src),
        .alu_ctrl(s_alu_ctrl), .rd(s_rd), .reg_write(s_reg_write), .forward_a(s_fa),
        .forward_b(s_fb), .ex_mem_fwd(s_exf), .wb_fwd(s_wbf), .stall(s_stall),
        .out_valid(s_out_valid), .out_result(s_out_result), .out_store_data(s_out_store_data),
        .out_branch_target(s_out_branch_target), .out_zero(s_out_zero), .out_rd(s_out_rd),
        .out_reg_write(s_out_reg_write)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; alu_src = 0; reg_write = 0; pc = 0; rd1 = 0; rd2 = 0;
        imm = 0; exf = 0; wbf = 0; alu_ctrl = 4'b0010; rd = 0; fa = 0; fb = 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        idle_inputs();
        in_valid = 1; alu_ctrl = op; rd1 = a; rd2 = b;
    endtask

    initial begin
        idle_inputs();
        s_in_valid = 0; s_flush = 0; s_alu_src = 0; s_reg_write = 0; s_pc = 0; s_rd1 = 0;
        s_rd2 = 0; s_imm = 0; s_exf = 0; s_wbf = 0; s_alu_ctrl = 0; s_rd = 0; s_fa = 0; s_fb = 0;

        // Reset state
        #12;
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_stall", {63'd0, stall}, 64'd0);
        check_eq("rst_result", out_result, 64'd0);
        check_eq("rst_zero", {63'd0, out_zero}, 64'd0);
        check_eq("rst_rd", {59'd0, out_rd}, 64'd0);
        check_eq("rst_target", out_branch_target, 64'd0);
        @(negedge clk);
        rst_n = 1;

        // ADD with EX/MEM forwarding on A and immediate B
        idle_inputs();
        in_valid = 1; alu_ctrl = 4'b0010; fa = 2'b10; exf = 64'd7; rd1 = 64'd100;
        alu_src = 1; imm = 64'd5; rd = 5'd3; reg_write = 1; pc = 64'h100;
        step();
        check_eq("add_result", out_result, 64'd12);
        check_eq("add_zero", {63'd0, out_zero}, 64'd0);
        check_eq("add_valid", {63'd0, out_valid}, 64'd1);
        check_eq("add_rd", {59'd0, out_rd}, 64'd3);
        check_eq("add_regw", {63'd0, out_reg_write}, 64'd1);
        check_eq("add_target", out_branch_target, 64'h114);

        // SUB 9-9 with WB forwarding on B
        idle_inputs();
        in_valid = 1; alu_ctrl = 4'b0110; rd1 = 64'd9; fb = 2'b01; wbf = 64'd9; rd2 = 64'd1;
        step();
        check_eq("sub_result", out_result, 64'd0);
        check_eq("sub_zero", {63'd0, out_zero}, 64'd1);
        check_eq("sub_store", out_store_data, 64'd9);

        // LSL with forward code 11 on A, shift amount masked to 6 bits
        idle_inputs();
        in_valid = 1; alu_ctrl = 4'b1001; fa = 2'b11; rd1 = 64'd1; exf = 64'h55; wbf = 64'h77;
        rd2 = 64'd70; pc = 64'h1000; imm = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        check_eq("lsl_result", out_result, 64'd64);
        check_eq("lsl_target", out_branch_target, 64'hFF8);

        // No valid instruction: bubble, data held
        idle_inputs();
        step();
        check_eq("bubble_valid", {63'd0, out_valid}, 64'd0);
        check_eq("bubble_hold", out_result, 64'd64);

        // Remaining ALU operations
        issue(4'b0000, 64'hF0F0, 64'h0FF0); step(); check_eq("and", out_result, 64'h00F0);
        issue(4'b0001, 64'hF000, 64'h000F); step(); check_eq("orr", out_result, 64'hF00F);
        issue(4'b1100, 64'h0, 64'hFF);      step(); check_eq("nor", out_result, 64'hFFFF_FFFF_FFFF_FF00);
        issue(4'b1010, 64'h80, 64'd3);      step(); check_eq("lsr", out_result, 64'h10);
        issue(4'b0111, 64'h1, 64'hABCD);    step(); check_eq("passb", out_result, 64'hABCD);
        issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2); step(); check_eq("add_wrap", out_result, 64'd1);
        issue(4'b1111, 64'd5, 64'd6);       step();
        check_eq("undef_result", out_result, 64'd0);
        check_eq("undef_zero", {63'd0, out_zero}, 64'd1);

        // MUL all-ones x 3: 16 busy edges, single valid pulse
        issue(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        rd = 5'd9; reg_write = 1;
        step();
        check_eq("mul_acc_stall", {63'd0, stall}, 64'd1);
        check_eq("mul_acc_valid", {63'd0, out_valid}, 64'd0);
        // Inputs change while busy and must be ignored
        issue(4'b0010, 64'd1, 64'd1);
        for (int i = 1; i < 16; i++) begin
            step();
            check_eq("mul_busy_stall", {63'd0, stall}, 64'd1);
            check_eq("mul_busy_valid", {63'd0, out_valid}, 64'd0);
        end
        idle_inputs();
        step();
        check_eq("mul_result", out_result, 64'hFFFF_FFFF_FFFF_FFFD);
        check_eq("mul_valid", {63'd0, out_valid}, 64'd1);
        check_eq("mul_stall_done", {63'd0, stall}, 64'd0);
        check_eq("mul_rd", {59'd0, out_rd}, 64'd9);
        step();
        check_eq("mul_pulse_end", {63'd0, out_valid}, 64'd0);

        // Flush during iteration 5 aborts the multiply
        issue(4'b1000, 64'd5, 64'd7);
        step();
        idle_inputs();
        repeat (4) step();
        check_eq("fl_pre_stall", {63'd0, stall}, 64'd1);
        flush = 1;
        step();
        flush = 0;
        check_eq("fl_stall", {63'd0, stall}, 64'd0);
        check_eq("fl_valid", {63'd0, out_valid}, 64'd0);
        for (int i = 0; i < 14; i++) begin
            step();
            check_eq("fl_no_pulse", {63'd0, out_valid}, 64'd0);
        end
        issue(4'b0010, 64'd2, 64'd3);
        step();
        check_eq("fl_add_result", out_result, 64'd5);
        check_eq("fl_add_valid", {63'd0, out_valid}, 64'd1);

        // Asynchronous reset in the middle of a multiply
        issue(4'b1000, 64'd3, 64'd4);
        rd = 5'd7; reg_write = 1; pc = 64'h40;
        step();
        idle_inputs();
        repeat (3) step();
        #2 rst_n = 0;
        #1;
        check_eq("arst_stall", {63'd0, stall}, 64'd0);
        check_eq("arst_result", out_result, 64'd0);
        check_eq("arst_store", out_store_data, 64'd0);
        check_eq("arst_target", out_branch_target, 64'd0);
        check_eq("arst_regw", {63'd0, out_reg_write}, 64'd0);
        @(negedge clk);
        rst_n = 1;

        // 32-bit / 8-bit digit instance: 4 busy edges
        s_in_valid = 1; s_alu_ctrl = 4'b1000; s_rd1 = 32'h1234; s_rd2 = 32'h10;
        step();
        s_in_valid = 0;
        check_eq("m32_stall", {63'd0, s_stall}, 64'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            check_eq("m32_busy_valid", {63'd0, s_out_valid}, 64'd0);
        end
        step();
        check_eq("m32_result", {32'd0, s_out_result}, 64'h12340);
        check_eq("m32_valid", {63'd0, s_out_valid}, 64'd1);
        check_eq("m32_stall_done", {63'd0, s_stall}, 64'd0);
        s_in_valid = 1; s_alu_ctrl = 4'b1111; s_rd1 = 32'd8; s_rd2 = 32'd8;
        step();
        s_in_valid = 0;
        check_eq("m32_undef_result", {32'd0, s_out_result}, 64'd0);
        check_eq("m32_undef_zero", {63'd0, s_out_zero}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
